// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sharing controller:
// opcode constants, FSM state encoding, default datapath width and the
// round-robin pick helper (used only when ALU_SHARE_RR_EN is defined).
package alu_share_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;
  localparam logic [2:0] OP_SRA = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // On a tie the requester that was not granted last wins; otherwise the
  // only active requester wins.
  function automatic logic pick_rr(input logic v0, input logic v1, input logic last_id);
    logic id;
    if (v0 && v1) begin
      id = ~last_id;
    end else begin
      id = v1;
    end
    return id;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu_core.sv
// Purely combinational ALU shared by both requesters. Opcodes 5, 6 and 7
// all perform an arithmetic right shift. Shifts use the full-width B, so
// amounts >= WIDTH give 0 (logical) or all sign bits (arithmetic).
module alu_core #(
  parameter int WIDTH = alu_share_ctrl_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] c
);
  import alu_share_ctrl_pkg::*;

  // Opcode decode and evaluation
  always_comb begin
    c = '0;
    case (op)
      OP_ADD:  c = a + b;
      OP_SUB:  c = a - b;
      OP_AND:  c = a & b;
      OP_OR:   c = a | b;
      OP_SRL:  c = a >> b;
      OP_SRA:  c = $unsigned($signed(a) >>> b);
      default: c = $unsigned($signed(a) >>> b);
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-requester controller time-sharing one combinational ALU.
// IDLE grants one requester and latches its operands, EXEC registers the
// ALU result, RESP presents it until the consumer takes it.
// Build option: define ALU_SHARE_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority and no pointer is built.
module alu_share_ctrl #(
  parameter int WIDTH = alu_share_ctrl_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic             busy
);
  import alu_share_ctrl_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_id;
  logic [WIDTH-1:0] r_rsp_c;
  logic             r_rsp_id;
  logic             r_rsp_valid;
  logic             r_busy;
  logic [WIDTH-1:0] w_alu_c;
  logic             w_grant;
  logic             w_grant_id;
  logic             w_handshake;

`ifdef ALU_SHARE_RR_EN
  logic r_ptr;
`endif

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a  (r_a),
    .b  (r_b),
    .op (r_op),
    .c  (w_alu_c)
  );

  // Arbitration: a grant is only possible in IDLE and never while reset is high
  always_comb begin
    w_grant    = 1'b0;
    w_grant_id = 1'b0;
    if ((r_state == ST_IDLE) && !reset && (req0_valid || req1_valid)) begin
      w_grant = 1'b1;
`ifdef ALU_SHARE_RR_EN
      w_grant_id = pick_rr(req0_valid, req1_valid, r_ptr);
`else
      w_grant_id = ~req0_valid;
`endif
    end else begin
      w_grant    = 1'b0;
      w_grant_id = 1'b0;
    end
  end

  assign req0_ready  = w_grant && !w_grant_id;
  assign req1_ready  = w_grant && w_grant_id;
  assign w_handshake = (r_state == ST_RESP) && rsp_ready;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_next = ST_EXEC;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RESP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the granted requester's operands and ID
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= 3'd0;
      r_id <= 1'b0;
    end else if (w_grant) begin
      r_a  <= w_grant_id ? req1_a  : req0_a;
      r_b  <= w_grant_id ? req1_b  : req0_b;
      r_op <= w_grant_id ? req1_op : req0_op;
      r_id <= w_grant_id;
    end
  end

  // Capture the ALU result at the end of EXEC; held unchanged through RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_c  <= '0;
      r_rsp_id <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_c  <= w_alu_c;
      r_rsp_id <= r_id;
    end
  end

  // Registered response-valid and busy flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (r_state == ST_EXEC) begin
        r_rsp_valid <= 1'b1;
      end else if (w_handshake) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_grant) begin
        r_busy <= 1'b1;
      end else if (w_handshake) begin
        r_busy <= 1'b0;
      end
    end
  end

`ifdef ALU_SHARE_RR_EN
  // Remember the last granted requester; reset value 1 lets requester 0 win first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b1;
    end else if (w_grant) begin
      r_ptr <= w_grant_id;
    end
  end
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_c     = r_rsp_c;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed vector table, random
// operations against an iterative reference model, and hand-written
// sequences for backpressure, asynchronous reset and simultaneous requests.
// Honours ALU_SHARE_RR_EN to select the expected arbitration rule.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

`ifdef ALU_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_c;

  int n_checks = 0;
  int n_fail   = 0;
  bit tb_ptr   = 1'b1;

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference ALU: shifts performed one bit at a time, up to B steps
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] r;
    logic        fill;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      default: begin
        fill = (op == 3'd4) ? 1'b0 : a[31];
        r = a;
        for (int i = 0; i < 32; i++) begin
          if (32'(i) < b) r = {fill, r[31:1]};
        end
      end
    endcase
    return r;
  endfunction

  // Expected winner given which requesters are valid
  function automatic bit ref_winner(input bit v0, input bit v1);
    if (v0 && v1) return RR ? ~tb_ptr : 1'b0;
    return v1;
  endfunction

  task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // One single-requester operation with rsp_ready held high; starts and ends at posedge+1
  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp, input string nm);
    rsp_ready = 1'b1;
    drive(id, a, b, op);
    if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
    #1;
    chk({nm, "_rdy0"}, 32'(req0_ready), 32'(!id));
    chk({nm, "_rdy1"}, 32'(req1_ready), 32'(id));
    tb_ptr = id;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({nm, "_exec_rv"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_exec_busy"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk({nm, "_rv"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_c"}, rsp_c, exp);
    chk({nm, "_id"}, 32'(rsp_id), 32'(id));
    @(posedge clk); #1;
    chk({nm, "_done_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done_rv"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_c, p0a, p0b, p1a, p1b;
    logic [2:0]  p0op, p1op;
    bit          w;

    vecs[0]  = '{1'b0, 32'd5,          32'd7,          3'd0, 32'd12};
    vecs[1]  = '{1'b1, 32'd0,          32'd1,          3'd1, 32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'd4,          3'd5, 32'hF800_0000};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'd4,          3'd4, 32'h0800_0000};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'd40,         3'd5, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  3'd2, 32'hF000_F000};
    vecs[6]  = '{1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  3'd3, 32'hFFF0_FFF0};
    vecs[7]  = '{1'b0, 32'h8000_0000,  32'd4,          3'd7, 32'hF800_0000};
    vecs[8]  = '{1'b0, 32'h7000_0000,  32'd4,          3'd6, 32'h0700_0000};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFF,  32'd1,          3'd0, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'd32,         3'd4, 32'h0000_0000};
    vecs[11] = '{1'b1, 32'h8000_0000,  32'd31,         3'd4, 32'h0000_0001};

    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    drive(1'b1, 32'd0, 32'd0, 3'd0);

    // Reset state, with both requesters asserting valid
    #12;
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_c", rsp_c, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); reset = 1'b0; tb_ptr = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      bit          rid;
      rid = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rop = 3'($urandom_range(0, 7));
      run_op(rid, ra, rb, rop, ref_alu(ra, rb, rop), $sformatf("rand%0d", i));
    end

    // Backpressure: hold rsp_ready low for 5 RESP cycles with requester 1 waiting
    rsp_ready = 1'b0;
    drive(1'b0, 32'h0000_1234, 32'h0000_0F0F, 3'd1);
    req0_valid = 1'b1;
    #1;
    chk("bp_grant0", 32'(req0_ready), 32'd1);
    tb_ptr = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive(1'b1, 32'hAAAA_0000, 32'h0000_5555, 3'd3);
    req1_valid = 1'b1;
    #1;
    chk("bp_exec_rdy1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    exp_c = ref_alu(32'h0000_1234, 32'h0000_0F0F, 3'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rv", 32'(rsp_valid), 32'd1);
      chk("bp_c", rsp_c, exp_c);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_rdy0", 32'(req0_ready), 32'd0);
      chk("bp_rdy1", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_rdy1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_after_rv", 32'(rsp_valid), 32'd0);
    chk("bp_after_rdy1", 32'(req1_ready), 32'd1);
    tb_ptr = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_r1_c", rsp_c, 32'hAAAA_5555);
    chk("bp_r1_id", 32'(rsp_id), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of EXEC
    drive(1'b0, 32'd5, 32'd7, 3'd0);
    req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2; reset = 1'b1; #1;
    chk("ar_rv", 32'(rsp_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_c", rsp_c, 32'd0);
    chk("ar_id", 32'(rsp_id), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("ar_rdy0", 32'(req0_ready), 32'd0);
    chk("ar_rdy1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); reset = 1'b0; tb_ptr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("ar_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Both requesters valid continuously with rsp_ready high
    p0a = $urandom; p0b = 32'($urandom_range(0, 40)); p0op = 3'($urandom_range(0, 7));
    p1a = $urandom; p1b = 32'($urandom_range(0, 40)); p1op = 3'($urandom_range(0, 7));
    drive(1'b0, p0a, p0b, p0op);
    drive(1'b1, p1a, p1b, p1op);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      w = ref_winner(1'b1, 1'b1);
      if (k == 0) chk("tie_first_is_0", 32'(req0_ready), 32'd1);
      chk("tie_rdy0", 32'(req0_ready), 32'(!w));
      chk("tie_rdy1", 32'(req1_ready), 32'(w));
      exp_c = w ? ref_alu(p1a, p1b, p1op) : ref_alu(p0a, p0b, p0op);
      tb_ptr = w;
      @(posedge clk); #1;
      if (w) begin
        p1a = $urandom; p1b = 32'($urandom_range(0, 40)); p1op = 3'($urandom_range(0, 7));
        drive(1'b1, p1a, p1b, p1op);
      end else begin
        p0a = $urandom; p0b = 32'($urandom_range(0, 40)); p0op = 3'($urandom_range(0, 7));
        drive(1'b0, p0a, p0b, p0op);
      end
      chk("tie_exec_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      @(posedge clk); #1;
      chk("tie_rv", 32'(rsp_valid), 32'd1);
      chk("tie_id", 32'(rsp_id), 32'(w));
      chk("tie_c", rsp_c, exp_c);
      chk("tie_resp_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
